// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with 16x oversampled bit timing, start and
//               stop validation, one-cycle ready/ferr strobes and break lockout.
//               Optional 3-sample majority voting: UART_RX_MAJORITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx #(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       ferr,
    output logic       busy
);

    localparam logic [13:0] c_div = 14'((CLK_HZ / BAUD) >> 4);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] c_start_tick = 4'd8;
`else
    localparam logic [3:0] c_start_tick = 4'd7;
`endif
    localparam logic [3:0] c_bit_tick = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic [13:0] div_q, div_d;
    logic [3:0]  tick_q, tick_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shr_q, shr_d;
    logic [7:0]  data_q, data_d;
    logic        ready_q, ready_d;
    logic        ferr_q, ferr_d;
    logic        armed_q, armed_d;

    logic        w_rxs;
    logic        w_tick;
    logic        w_bit;

    assign w_rxs  = sync_q[1];
    assign w_tick = (div_q == c_div);

`ifdef UART_RX_MAJORITY_EN
    // Two previous tick samples plus the current one form the 3-sample vote.
    logic [1:0] vote_q, vote_d;

    assign w_bit  = (vote_q[1] & vote_q[0]) | (vote_q[1] & w_rxs) | (vote_q[0] & w_rxs);
    assign vote_d = w_tick ? {vote_q[0], w_rxs} : vote_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vote_q <= 2'b11;
        end else begin
            vote_q <= vote_d;
        end
    end
`else
    assign w_bit = w_rxs;
`endif

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], data_in};
        div_d   = w_tick ? 14'd0 : div_q + 14'd1;
        tick_d  = w_tick ? tick_q + 4'd1 : tick_q;
        bit_d   = bit_q;
        shr_d   = shr_q;
        data_d  = data_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
        armed_d = armed_q;

        case (state_q)
            S_IDLE: begin
                if (w_rxs) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = S_START;
                    div_d   = 14'd0;
                    tick_d  = 4'd0;
                end
            end
            S_START: begin
                if (w_tick && tick_q == c_start_tick) begin
                    if (!w_bit) begin
                        state_d = S_DATA;
                        tick_d  = 4'd0;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_tick && tick_q == c_bit_tick) begin
                    shr_d = {w_bit, shr_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Leaving at mid-stop-bit keeps back-to-back frames catchable.
                if (w_tick && tick_q == c_bit_tick) begin
                    state_d = S_IDLE;
                    if (w_bit) begin
                        data_d  = shr_q;
                        ready_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync_q  <= 2'b11;
            div_q   <= 14'd0;
            tick_q  <= 4'd0;
            bit_q   <= 3'd0;
            shr_q   <= 8'h00;
            data_q  <= 8'h00;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shr_q   <= shr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
        end
    end

    assign data_out = data_q;
    assign ready    = ready_q;
    assign ferr     = ferr_q;
    assign busy     = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Scoreboard testbench for uart_rx (scaled baud timing).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

    localparam int CLK_HZ = 6400000;
    localparam int BAUD   = 100000;
    localparam int T      = ((CLK_HZ / BAUD) >> 4) + 1;
    localparam int BIT    = 16 * T;
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMP = 9;
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam int SAMP = 8;
    localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif
    // Cycles from the line going low to the strobe cycle.
    localparam int LAT = (SAMP + 144) * T + 3;

    logic       clk;
    logic       rst;
    logic       data_in;
    logic [7:0] data_out;
    logic       ready;
    logic       ferr;
    logic       busy;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (data_out),
        .ready    (ready),
        .ferr     (ferr),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         when;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_err = 0;
    int         busy_cnt = 0;
    logic [7:0] exp_last = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy) busy_cnt <= busy_cnt + 1;
        if (!rst && (ready || ferr)) begin
            if (sb.size() == 0) begin
                check("spurious_strobe", {30'd0, ready, ferr}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_kind", {30'd0, ready, ferr}, {30'd0, ~mon_e.is_err, mon_e.is_err});
                check("data_out", {24'd0, data_out}, {24'd0, mon_e.is_err ? exp_last : mon_e.data});
                check("strobe_cycle", cyc, mon_e.when);
                if (!mon_e.is_err) exp_last = mon_e.data;
            end
        end
    end

    task automatic hold(input logic v, input int n);
        data_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        sb.push_back('{is_err: ~stop, data: b, when: cyc + LAT});
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(b[i], BIT);
        hold(stop, BIT);
    endtask

    initial begin
        rst     = 1'b1;
        data_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_out", {24'd0, data_out}, 32'h00);
        check("rst_strobes", {30'd0, ready, ferr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        hold(1'b1, 2 * BIT);

        send(8'hA5, 1'b1);
        hold(1'b1, 2 * BIT);

        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        hold(1'b1, 2 * BIT);

        // Short low pulse: false start, busy for exactly the start-sample window.
        busy_cnt = 0;
        hold(1'b0, 3 * T);
        hold(1'b1, 2 * BIT);
        check("glitch_busy_cycles", busy_cnt, SAMP * T);

        // Framing error followed by a break: no retrigger until line returns high.
        send(8'h3C, 1'b0);
        hold(1'b0, 30 * BIT);
        hold(1'b1, 2 * BIT);
        send(8'h11, 1'b1);
        hold(1'b1, 2 * BIT);

        // Reset in the middle of bit 4 of 0x77.
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(1'b1 & (8'h77 >> i), BIT);
        hold(1'b1, BIT / 2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_data_out", {24'd0, data_out}, 32'h00);
        check("midrst_strobes", {30'd0, ready, ferr}, 32'd0);
        exp_last = 8'h00;
        @(posedge clk);
        #1 rst = 1'b0;
        hold(1'b1, 2 * BIT);
        send(8'h5A, 1'b1);
        hold(1'b1, 2 * BIT);

        // 0x00 with a one-clock high glitch on the bit-2 centre sample.
        sb.push_back('{is_err: 1'b0, data: GLITCH_EXP, when: cyc + LAT});
        hold(1'b0, 56 * T);
        hold(1'b1, 1);
        hold(1'b0, 9 * BIT - 56 * T - 1);
        hold(1'b1, BIT);
        hold(1'b1, 2 * BIT);

        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
